branch_sched: RTL

In-order scheduler that buffers branch instructions from issue logic and feeds them one at a time to the single branch evaluation unit. It sits between the issue stage and the branch evaluation unit, replacing a direct issue-to-unit write path. Queued entries snoop the CDB so their operands stay current. On a mispredict reported by the unit, the scheduler flushes all younger queued branches.

---
 rtl/branch_sched_if.sv | 53 +++++
 rtl/branch_sched.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/branch_sched_if.sv
// Issue-side, branch-unit and resolution signals of branch_sched bundled into one interface.
// master drives issue/CDB/unit responses; slave is the scheduler.
interface branch_sched_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef logic [3:0]  rs_tag_t;
  typedef logic [31:0] word32_t;
  typedef logic [2:0]  branch_op_t;
  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

  cdb_t             cdb_i;
  logic             enq_i;
  branch_op_t       enq_op_i;
  rs_tag_t          enq_tag1_i;
  rs_tag_t          enq_tag2_i;
  word32_t          enq_val1_i;
  word32_t          enq_val2_i;
  logic             enq_pred_i;
  logic             full_o;
  logic [CNT_W-1:0] count_o;

  logic             bu_write_o;
  branch_op_t       bu_op_o;
  rs_tag_t          bu_tag1_o;
  rs_tag_t          bu_tag2_o;
  word32_t          bu_val1_o;
  word32_t          bu_val2_o;
  logic             bu_pred_o;
  logic             bu_cond_eval_i;
  logic             bu_corr_pred_i;

  logic             resolve_o;
  logic             mispredict_o;

  modport master (
    output cdb_i, enq_i, enq_op_i, enq_tag1_i, enq_tag2_i, enq_val1_i, enq_val2_i,
           enq_pred_i, bu_cond_eval_i, bu_corr_pred_i,
    input  full_o, count_o, bu_write_o, bu_op_o, bu_tag1_o, bu_tag2_o, bu_val1_o,
           bu_val2_o, bu_pred_o, resolve_o, mispredict_o
  );

  modport slave (
    input  cdb_i, enq_i, enq_op_i, enq_tag1_i, enq_tag2_i, enq_val1_i, enq_val2_i,
           enq_pred_i, bu_cond_eval_i, bu_corr_pred_i,
    output full_o, count_o, bu_write_o, bu_op_o, bu_tag1_o, bu_tag2_o, bu_val1_o,
           bu_val2_o, bu_pred_o, resolve_o, mispredict_o
  );
endinterface

// File: rtl/branch_sched.sv
// In-order branch scheduler: circular FIFO with CDB snooping that feeds one branch unit at a time.
// Define BRANCH_SCHED_STATS_EN to add saturating resolved/mispredicted counters.
module branch_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
`ifdef BRANCH_SCHED_STATS_EN
  output logic [31:0] resolved_cnt_o,
  output logic [31:0] mispred_cnt_o,
`endif
  branch_sched_if.slave bus
);
  // state     | meaning
  // IDLE      | no branch in the unit; dispatch head when queue non-empty
  // WAIT_EVAL | head written to the unit; waiting for bu_cond_eval_i
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] NO_VAL = 4'd0;

  typedef enum logic {IDLE, WAIT_EVAL} state_e;
  state_e state_q, state_d;

  logic [2:0]       op_q   [DEPTH];
  logic [2:0]       op_d   [DEPTH];
  logic [3:0]       tag1_q [DEPTH];
  logic [3:0]       tag1_d [DEPTH];
  logic [3:0]       tag2_q [DEPTH];
  logic [3:0]       tag2_d [DEPTH];
  logic [31:0]      val1_q [DEPTH];
  logic [31:0]      val1_d [DEPTH];
  logic [31:0]      val2_q [DEPTH];
  logic [31:0]      val2_d [DEPTH];
  logic             pred_q [DEPTH];
  logic             pred_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        full, do_enq, pop, resolve, mispredict, bu_write;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;

  // Replace a pending operand with the broadcast value when its tag is on the CDB.
  function automatic logic [35:0] fwd(input logic [3:0] tag, input logic [31:0] val,
                                      input logic [3:0] ctag, input logic [31:0] cval);
    if (tag != NO_VAL && tag == ctag) return {NO_VAL, cval};
    return {tag, val};
  endfunction

  assign cdb_tag = bus.cdb_i.tag;
  assign cdb_val = bus.cdb_i.val;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_enq  = bus.enq_i && !full;

  always_comb begin
    state_d    = state_q;
    bu_write   = 1'b0;
    pop        = 1'b0;
    resolve    = 1'b0;
    mispredict = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          bu_write = 1'b1;
          pop      = 1'b1;
          state_d  = WAIT_EVAL;
        end
      end
      WAIT_EVAL: begin
        if (bus.bu_cond_eval_i) begin
          resolve    = 1'b1;
          mispredict = ~bus.bu_corr_pred_i;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    pred_d  = pred_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      {tag1_d[i], val1_d[i]} = fwd(tag1_q[i], val1_q[i], cdb_tag, cdb_val);
      {tag2_d[i], val2_d[i]} = fwd(tag2_q[i], val2_q[i], cdb_tag, cdb_val);
    end
    // A mispredict kills everything queued, including a same-cycle enqueue.
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) begin
        op_d[tail_q]   = bus.enq_op_i;
        pred_d[tail_q] = bus.enq_pred_i;
        {tag1_d[tail_q], val1_d[tail_q]} = fwd(bus.enq_tag1_i, bus.enq_val1_i, cdb_tag, cdb_val);
        {tag2_d[tail_q], val2_d[tail_q]} = fwd(bus.enq_tag2_i, bus.enq_val2_i, cdb_tag, cdb_val);
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_enq) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        pred_q[i] <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      op_q    <= op_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      pred_q  <= pred_d;
    end
  end

  // Head is forwarded so the unit never misses a broadcast landing in its write cycle.
  assign {bus.bu_tag1_o, bus.bu_val1_o} = fwd(tag1_q[head_q], val1_q[head_q], cdb_tag, cdb_val);
  assign {bus.bu_tag2_o, bus.bu_val2_o} = fwd(tag2_q[head_q], val2_q[head_q], cdb_tag, cdb_val);
  assign bus.bu_op_o      = op_q[head_q];
  assign bus.bu_pred_o    = pred_q[head_q];
  assign bus.bu_write_o   = bu_write;
  assign bus.full_o       = full;
  assign bus.count_o      = count_q;
  assign bus.resolve_o    = resolve;
  assign bus.mispredict_o = mispredict;

`ifdef BRANCH_SCHED_STATS_EN
  logic [31:0] resolved_cnt_q, resolved_cnt_d, mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    resolved_cnt_d = resolved_cnt_q;
    mispred_cnt_d  = mispred_cnt_q;
    if (resolve && resolved_cnt_q != '1)   resolved_cnt_d = resolved_cnt_q + 32'd1;
    if (mispredict && mispred_cnt_q != '1) mispred_cnt_d  = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resolved_cnt_q <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      resolved_cnt_q <= resolved_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  assign resolved_cnt_o = resolved_cnt_q;
  assign mispred_cnt_o  = mispred_cnt_q;
`endif
endmodule
